gba_line_streamer: RTL
======================

# gba_line_streamer

Producer side of the GBA pixel-write interface consumed by the HDMI frame-buffer converter. When the PPU finishes a scanline in its 240-entry BGR555 line buffer, this block reads the buffer back, expands each pixel to RGB6, and emits one `pixel_we` write per pixel with `pixel_x`/`pixel_y` coordinates. It sits between the PPU line buffer and the frame-buffer writer, in the `clk` domain, and throttles writes so the consumer's BRAM port is never overrun.

## Interface
Parameters:
- `PIXEL_GAP`, default 0: idle cycles inserted after each pixel write (0–15); one pixel occupies `1+PIXEL_GAP` cycles.

Ports:
- `clk` in 1: system clock (single clock domain).
- `resetn` in 1: reset, asynchronous, active-low.
- `line_valid` in 1: one-cycle pulse, scanline `line_y` is complete in the line buffer.
- `line_y` in 8: scanline number, sampled with `line_valid`.
- `lb_re` out 1: line-buffer read enable.
- `lb_addr` out 8: line-buffer read address, 0–239.
- `lb_rdata` in 15: BGR555 pixel (`[4:0]` R, `[9:5]` G, `[14:10]` B), valid the cycle after `lb_re`.
- `pixel_we` out 1: pixel write strobe.
- `pixel_x` out 8: pixel column 0–239.
- `pixel_y` out 8: pixel row 0–159.
- `pixel_data` out 18: RGB6 `{R6,G6,B6}`.
- `busy` out 1: a line is streaming.
- `frame_done` out 1: one-cycle pulse after the last write of row 159.
- `overrun` out 1: sticky, a line request was dropped.

## Operation
- States: IDLE, READ, WRITE, GAP.
  - IDLE → READ on an accepted line.
  - READ: `lb_re=1`, `lb_addr=x`; → WRITE.
  - WRITE: `pixel_we=1`, `pixel_x=x`, `pixel_y` = latched row, `pixel_data` = expansion of `lb_rdata`.
    - If `x==239`: → IDLE, or → READ with x=0 if a request is pending.
    - Otherwise x increments and the state goes to GAP (if `PIXEL_GAP>0`) or READ.
  - GAP: counts `PIXEL_GAP` cycles → READ.
  - With `PIXEL_GAP=0`, READ for pixel x+1 overlaps WRITE of pixel x, so a write issues every cycle.
- Colour expansion: each 5-bit channel c becomes `{c, c[4]}`. 0 maps to 0 and 31 maps to 63.
- Requests with `line_y >= 160` (vblank) are ignored silently: no stream, no overrun.
- One-deep pending slot:
  - `line_valid` while busy (including the final WRITE cycle) with the slot empty latches `line_y` into the slot.
  - If the slot is full, the request is dropped and `overrun` is set. Only reset clears `overrun`.
- A pending line starts as if `line_valid` arrived in the final WRITE cycle of the current line.
- `frame_done` pulses the cycle after the WRITE with x=239 and y=159.
- Reset mid-line aborts immediately: no further writes, the pending slot is cleared.
- Reset values: all outputs 0; state IDLE.

## Timing
- Cycle 0: `line_valid` high while IDLE.
- Cycle 1: `lb_re=1`, `lb_addr=0`, `busy=1`.
- Pixel k write occurs in cycle `2 + k*(1+PIXEL_GAP)`.
- Last write (k=239) occurs in cycle `2 + 239*(1+PIXEL_GAP)`: cycle 241 for gap 0.
- `busy` is high from cycle 1 through the last write cycle.
- All outputs are registered; `pixel_data` is registered from `lb_rdata` in the WRITE cycle.
- A pending line's first `lb_re` comes the cycle after the last write, and its first write one cycle after that.
- Lines are never interleaved; a line stream is never interrupted except by reset.

## Configuration
- `GBA_STREAMER_TESTPAT_EN`: when defined, `pixel_data` is the pattern `{x[5:0], y[5:0], x[5:0]^y[5:0]}` instead of the expanded `lb_rdata`. `lb_re` and `lb_addr` still toggle, and timing is unchanged.
- When undefined, the pattern logic is absent and `pixel_data` is always the colour expansion.

## Structure
- Shared package `gba_video_pkg` holds:
  - constants `GBA_W=240` and `GBA_H=160`;
  - typedefs `bgr5_t` (15 bit) and `rgb6_t` (18 bit);
  - function `bgr5_to_rgb6`.
- The converter should also import these.
- No sub-module: the state machine, counters and pending slot stay in one module.

## Test plan
- `PIXEL_GAP=0`, `line_valid` with `line_y=5`, buffer filled with `0x7FFF`: 240 consecutive `pixel_we` in cycles 2–241, `pixel_y=5`, `pixel_data=0x3FFFF`, x running 0..239, `busy` falls at cycle 242.
- Buffer entry `0x001F` at x=3 and `0x7C00` at x=4: `pixel_data` is `0x3F000` at x=3 and `0x0003F` at x=4.
- `PIXEL_GAP=2`: writes occur in cycles 2, 5, 8, …; the last write is at cycle 719.
- `line_valid` y=10 then y=11 and y=12 during streaming: rows 10 and 11 stream back-to-back with the first `lb_re` of row 11 the cycle after the last write of row 10; row 12 is dropped and `overrun=1`.
- Row 159 streamed: `frame_done` pulses exactly one cycle after the x=239 write. A request with `line_y=160` produces no writes and leaves `overrun=0`.
- `resetn` low at pixel 100: outputs go to 0 immediately, and no writes follow after release until the next `line_valid`.

Source files
------------

// File: rtl/gba_video_pkg.sv
// gba_video_pkg: shared GBA video constants, pixel types, colour expansion and streamer states
package gba_video_pkg;

    localparam int GBA_W = 240;
    localparam int GBA_H = 160;

    typedef logic [14:0] bgr5_t;
    typedef logic [17:0] rgb6_t;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_GAP} streamer_state_t;

    // Replicating each channel's MSB into the new LSB maps 0->0 and 31->63.
    function automatic rgb6_t bgr5_to_rgb6(input bgr5_t p);
        return {p[4:0], p[4], p[9:5], p[9], p[14:10], p[14]};
    endfunction

endpackage

// File: rtl/gba_line_streamer.sv
// gba_line_streamer: replays a finished PPU scanline as throttled RGB6 pixel writes.
// GBA_STREAMER_TESTPAT_EN replaces pixel_data with a coordinate test pattern.
module gba_line_streamer
    import gba_video_pkg::*;
#(
    parameter int PIXEL_GAP = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        line_valid,
    input  logic [7:0]  line_y,
    output logic        lb_re,
    output logic [7:0]  lb_addr,
    input  logic [14:0] lb_rdata,
    output logic        pixel_we,
    output logic [7:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic [17:0] pixel_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    streamer_state_t r_state, w_next;
    logic [7:0] r_x, w_x, r_y, w_y, r_pend_y, w_pend_y, r_px, r_py;
    logic [3:0] r_gap, w_gap;
    logic       r_pend_v, w_pend_v, r_ovf, w_ovf, r_we, r_done;
    logic       w_req, w_final;

    assign lb_re      = (r_state == ST_READ);
    assign lb_addr    = r_x;
    assign busy       = (r_state != ST_IDLE);
    assign pixel_we   = r_we;
    assign pixel_x    = r_px;
    assign pixel_y    = r_py;
    assign frame_done = r_done;
    assign overrun    = r_ovf;

`ifdef GBA_STREAMER_TESTPAT_EN
    assign pixel_data = r_we ? {r_px[5:0], r_py[5:0], r_px[5:0] ^ r_py[5:0]} : '0;
`else
    assign pixel_data = r_we ? bgr5_to_rgb6(lb_rdata) : '0;
`endif

    // Next state: read scheduling, gap counting, line start/chaining and the one-deep request slot
    always_comb begin
        w_next   = r_state;
        w_x      = r_x;
        w_y      = r_y;
        w_gap    = r_gap;
        w_pend_v = r_pend_v;
        w_pend_y = r_pend_y;
        w_ovf    = r_ovf;
        w_req    = line_valid && (line_y < 8'(GBA_H));
        w_final  = (r_state == ST_WRITE) && (r_px == 8'(GBA_W - 1));
        case (r_state)
            ST_IDLE: if (w_req) begin
                w_next = ST_READ;
                w_x    = '0;
                w_y    = line_y;
            end
            ST_READ: if (r_x == 8'(GBA_W - 1)) begin
                w_next = ST_WRITE;
            end else begin
                w_x    = r_x + 8'd1;
                w_next = (PIXEL_GAP == 0) ? ST_READ : ST_WRITE;
            end
            ST_WRITE: if (w_final) begin
                w_x    = '0;
                w_next = (r_pend_v || w_req) ? ST_READ : ST_IDLE;
                w_y    = r_pend_v ? r_pend_y : line_y;
                w_pend_v = 1'b0;
            end else begin
                w_next = (PIXEL_GAP > 1) ? ST_GAP : ST_READ;
                w_gap  = 4'(PIXEL_GAP - 1);
            end
            ST_GAP: begin
                w_gap  = r_gap - 4'd1;
                w_next = (r_gap == 4'd1) ? ST_READ : ST_GAP;
            end
            default: w_next = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && w_req && !(w_final && !r_pend_v)) begin
            if (r_pend_v) begin
                w_ovf = 1'b1;
            end else begin
                w_pend_v = 1'b1;
                w_pend_y = line_y;
            end
        end
    end

    // State, counters and registered write outputs; the write trails its read by one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_gap    <= '0;
            r_pend_v <= 1'b0;
            r_pend_y <= '0;
            r_ovf    <= 1'b0;
            r_we     <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_x      <= w_x;
            r_y      <= w_y;
            r_gap    <= w_gap;
            r_pend_v <= w_pend_v;
            r_pend_y <= w_pend_y;
            r_ovf    <= w_ovf;
            r_we     <= (r_state == ST_READ);
            r_px     <= (r_state == ST_READ) ? r_x : r_px;
            r_py     <= (r_state == ST_READ) ? r_y : r_py;
            r_done   <= w_final && (r_py == 8'(GBA_H - 1));
        end
    end

endmodule
